// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states and
// lane helpers.
package load_store_unit_pkg;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  localparam int unsigned BYTE_BITS = 8;
  localparam int unsigned HALF_BITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  function automatic logic size_legal(input logic [2:0] size);
    case (size)
      SIZE_B, SIZE_H, SIZE_W, SIZE_BU, SIZE_HU: size_legal = 1'b1;
      default:                                  size_legal = 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      SIZE_H, SIZE_HU: misaligned = lo[0];
      SIZE_W:          misaligned = (lo != 2'b00);
      default:         misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory bus between datapath, unit and memory.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  reqValid;
  logic                  reqReady;
  logic                  reqWrite;
  logic [2:0]            reqSize;
  logic [ADDR_WIDTH-1:0] reqAddr;
  logic [31:0]           reqWData;
  logic                  respValid;
  logic [31:0]           respData;
  logic                  respErr;
  logic [ADDR_WIDTH-1:0] memAdr;
  logic [31:0]           memWriteData;
  logic                  memWrite;
  logic [31:0]           memReadData;

  // the unit itself
  modport slave (
    input  reqValid, reqWrite, reqSize, reqAddr, reqWData, memReadData,
    output reqReady, respValid, respData, respErr, memAdr, memWriteData, memWrite
  );

  // datapath plus memory surrounding the unit
  modport master (
    output reqValid, reqWrite, reqSize, reqAddr, reqWData, memReadData,
    input  reqReady, respValid, respData, respErr, memAdr, memWriteData, memWrite
  );
endinterface

// File: rtl/load_store_unit_lane_unit.sv
// Combinational lane logic: load extraction with sign/zero extension and
// sub-word store merge into the word read from memory.
module lsu_lane_unit
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [BYTE_BITS-1:0] byte_s;
  logic [HALF_BITS-1:0] half_s;

  // load path: pick the lane, then extend according to the size code
  always_comb begin
    byte_s = rdata_i[{lane_i, 3'b000} +: BYTE_BITS];
    half_s = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SIZE_B:  load_o = {{24{byte_s[7]}}, byte_s};
      SIZE_BU: load_o = {24'h000000, byte_s};
      SIZE_H:  load_o = {{16{half_s[15]}}, half_s};
      SIZE_HU: load_o = {16'h0000, half_s};
      default: load_o = rdata_i;
    endcase
  end

  // store path: overwrite only the selected lane of the read word
  always_comb begin
    merge_o = rdata_i;
    case (size_i[1:0])
      2'b00:   merge_o[{lane_i, 3'b000} +: BYTE_BITS] = wdata_i[7:0];
      2'b01:   merge_o[{lane_i[1], 4'b0000} +: HALF_BITS] = wdata_i[15:0];
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: request FSM driving a word-addressed memory with RMW for
// sub-word stores. Define LSU_MISALIGN_CHECK_EN to reject misaligned h/w accesses.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rstN,
  load_store_unit_if.slave   bus
);

  lsu_state_e            state_q, state_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [31:0]           data_q, data_d;
  logic [31:0]           merge_q, merge_d;
  logic                  err_q, err_d;
  logic                  illegal_s;
  logic [31:0]           load_s, merge_s;

  lsu_lane_unit u_lane (
    .size_i  (size_q),
    .lane_i  (addr_q[1:0]),
    .rdata_i (bus.memReadData),
    .wdata_i (wdata_q),
    .load_o  (load_s),
    .merge_o (merge_s)
  );

  // request legality, with optional alignment rejection
  always_comb begin
`ifdef LSU_MISALIGN_CHECK_EN
    illegal_s = !size_legal(bus.reqSize) || misaligned(bus.reqSize, bus.reqAddr[1:0]);
`else
    illegal_s = !size_legal(bus.reqSize);
`endif
  end

  // next-state and outputs; memWrite decodes from state so reset kills it at once
  always_comb begin
    state_d          = state_q;
    write_d          = write_q;
    size_d           = size_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    data_d           = data_q;
    merge_d          = merge_q;
    err_d            = err_q;
    bus.reqReady     = 1'b0;
    bus.respValid    = 1'b0;
    bus.memWrite     = 1'b0;
    bus.memWriteData = 32'h0000_0000;
    bus.memAdr       = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    case (state_q)
      ST_IDLE: begin
        bus.reqReady = 1'b1;
        if (bus.reqValid) begin
          write_d = bus.reqWrite;
          size_d  = bus.reqSize;
          addr_d  = bus.reqAddr;
          wdata_d = bus.reqWData;
          data_d  = 32'h0000_0000;
          err_d   = illegal_s;
          state_d = illegal_s ? ST_RESP : ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!write_q) begin
          data_d  = load_s;
          state_d = ST_RESP;
        end else if (size_q[1]) begin
          bus.memWrite     = 1'b1;
          bus.memWriteData = wdata_q;
          state_d          = ST_RESP;
        end else begin
          merge_d = merge_s;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        bus.memWrite     = 1'b1;
        bus.memWriteData = merge_q;
        state_d          = ST_RESP;
      end
      ST_RESP: begin
        bus.respValid = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.respData = data_q;
  assign bus.respErr  = err_q;

  // state and request registers
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      size_q  <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= 32'h0000_0000;
      merge_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      merge_q <= merge_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [3:0]  lat;
    logic [3:0]  wr;
  } exp_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic [31:0] mem [0:255];
  exp_t exp_q[$];
  int   acc_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  bit   busy = 1'b0;
  logic [31:0] word40;

  load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

  load_store_unit dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.memReadData = mem[bus.memAdr[9:2]];

  always @(posedge clk) begin
    if (bus.memWrite) mem[bus.memAdr[9:2]] <= bus.memWriteData;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // monitor: latency, write count, busy-ready and response contents
  always @(negedge clk) begin
    if (!rstN) begin
      acc_q.delete();
      busy   = 1'b0;
      wr_cnt = 0;
    end else begin
      cyc++;
      if (busy) chk("busy_ready", {31'd0, bus.reqReady}, 32'd0);
      if (bus.memWrite) wr_cnt++;
      if (bus.respValid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          int a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("resp_data", bus.respData, e.data);
          chk("resp_err", {31'd0, bus.respErr}, {31'd0, e.err});
          chk("latency", cyc - a, {28'd0, e.lat});
          chk("write_cycles", wr_cnt, {28'd0, e.wr});
          chk("memwrite_in_resp", {31'd0, bus.memWrite}, 32'd0);
        end
        wr_cnt = 0;
        busy   = 1'b0;
      end
      if (bus.reqValid && bus.reqReady) begin
        acc_q.push_back(cyc);
        busy = 1'b1;
      end
    end
  end

  task automatic issue(input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                       input logic [3:0] el, input logic [3:0] ew, input bit hold,
                       input bit want_resp);
    int t;
    exp_t e;
    e = '{data: ed, err: ee, lat: el, wr: ew};
    if (want_resp) exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.reqValid = 1'b1;
    bus.reqWrite = wr;
    bus.reqSize  = sz;
    bus.reqAddr  = addr;
    bus.reqWData = wd;
    t = 0;
    @(negedge clk);
    while (!bus.reqReady && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    if (!hold) bus.reqValid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("drain", exp_q.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
    mem[8'h40] = 32'h8899_AABB;
    bus.reqValid = 1'b0;
    bus.reqWrite = 1'b0;
    bus.reqSize  = 3'b000;
    bus.reqAddr  = 32'h0000_0000;
    bus.reqWData = 32'h0000_0000;
    #12;
    chk("rst_ready", {31'd0, bus.reqReady}, 32'd1);
    chk("rst_respvalid", {31'd0, bus.respValid}, 32'd0);
    chk("rst_respdata", bus.respData, 32'd0);
    chk("rst_resperr", {31'd0, bus.respErr}, 32'd0);
    chk("rst_memwrite", {31'd0, bus.memWrite}, 32'd0);
    chk("rst_memadr", bus.memAdr, 32'd0);
    chk("rst_memwdata", bus.memWriteData, 32'd0);
    #10 rstN = 1'b1;

    // loads from word 0x100 = 0x8899AABB
    issue(1'b0, SIZE_B,  32'h101, 32'h0, 32'hFFFF_FFAA, 1'b0, 4'd2, 4'd0, 1'b0, 1'b1); drain();
    issue(1'b0, SIZE_BU, 32'h103, 32'h0, 32'h0000_0088, 1'b0, 4'd2, 4'd0, 1'b0, 1'b1); drain();
    issue(1'b0, SIZE_H,  32'h102, 32'h0, 32'hFFFF_8899, 1'b0, 4'd2, 4'd0, 1'b0, 1'b1); drain();
    issue(1'b0, SIZE_HU, 32'h100, 32'h0, 32'h0000_AABB, 1'b0, 4'd2, 4'd0, 1'b0, 1'b1); drain();
    issue(1'b0, SIZE_W,  32'h100, 32'h0, 32'h8899_AABB, 1'b0, 4'd2, 4'd0, 1'b0, 1'b1); drain();

    // stores
    issue(1'b1, SIZE_B, 32'h102, 32'hFFFF_FF12, 32'h0, 1'b0, 4'd3, 4'd1, 1'b0, 1'b1); drain();
    chk("mem_sb", mem[8'h40], 32'h8812_AABB);
    issue(1'b1, SIZE_H, 32'h100, 32'hFFFF_3456, 32'h0, 1'b0, 4'd3, 4'd1, 1'b0, 1'b1); drain();
    chk("mem_sh", mem[8'h40], 32'h8812_3456);
    issue(1'b1, SIZE_W, 32'h104, 32'hDEAD_BEEF, 32'h0, 1'b0, 4'd2, 4'd1, 1'b0, 1'b1); drain();
    chk("mem_sw", mem[8'h41], 32'hDEAD_BEEF);

    // back-to-back with reqValid held high
    issue(1'b0, SIZE_W, 32'h104, 32'h0,  32'hDEAD_BEEF, 1'b0, 4'd2, 4'd0, 1'b1, 1'b1);
    issue(1'b1, SIZE_B, 32'h107, 32'h55, 32'h0,         1'b0, 4'd3, 4'd1, 1'b0, 1'b1); drain();
    chk("mem_b2b", mem[8'h41], 32'h55AD_BEEF);

    // illegal size codes
    issue(1'b1, 3'b011, 32'h100, 32'h1111_1111, 32'h0, 1'b1, 4'd1, 4'd0, 1'b0, 1'b1); drain();
    issue(1'b0, 3'b110, 32'h100, 32'h0,         32'h0, 1'b1, 4'd1, 4'd0, 1'b0, 1'b1); drain();
    issue(1'b1, 3'b111, 32'h104, 32'h2222_2222, 32'h0, 1'b1, 4'd1, 4'd0, 1'b0, 1'b1); drain();
    chk("mem_err_40", mem[8'h40], 32'h8812_3456);

`ifdef LSU_MISALIGN_CHECK_EN
    issue(1'b1, SIZE_W, 32'h102, 32'hCAFE_F00D, 32'h0, 1'b1, 4'd1, 4'd0, 1'b0, 1'b1); drain();
    word40 = 32'h8812_3456;
    chk("mem_sw_mis", mem[8'h40], word40);
    issue(1'b0, SIZE_H, 32'h101, 32'h0, 32'h0, 1'b1, 4'd1, 4'd0, 1'b0, 1'b1); drain();
`else
    issue(1'b1, SIZE_W, 32'h102, 32'hCAFE_F00D, 32'h0, 1'b0, 4'd2, 4'd1, 1'b0, 1'b1); drain();
    word40 = 32'hCAFE_F00D;
    chk("mem_sw_mis", mem[8'h40], word40);
    issue(1'b0, SIZE_H, 32'h101, 32'h0, 32'hFFFF_F00D, 1'b0, 4'd2, 4'd0, 1'b0, 1'b1); drain();
`endif

    // reset during the ACCESS cycle of a halfword store
    issue(1'b1, SIZE_H, 32'h100, 32'h7777, 32'h0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    #1 rstN = 1'b0;
    #1;
    chk("midrst_memwrite", {31'd0, bus.memWrite}, 32'd0);
    chk("midrst_ready", {31'd0, bus.reqReady}, 32'd1);
    chk("midrst_respvalid", {31'd0, bus.respValid}, 32'd0);
    chk("midrst_memadr", bus.memAdr, 32'd0);
    chk("midrst_memwdata", bus.memWriteData, 32'd0);
    repeat (3) @(negedge clk);
    #2 rstN = 1'b1;
    @(negedge clk);
    chk("midrst_mem", mem[8'h40], word40);
    chk("post_rst_ready", {31'd0, bus.reqReady}, 32'd1);
    issue(1'b0, SIZE_W, 32'h100, 32'h0, word40, 1'b0, 4'd2, 4'd0, 1'b0, 1'b1); drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the word-addressed data memory interface. The memory reads combinationally, writes synchronously, uses little-endian byte lanes, and ignores address bits [1:0].
- Accepts byte, halfword and word load/store requests from the multi-cycle datapath through a valid/ready request and a one-cycle response pulse.
- Performs lane extraction and sign/zero extension on loads.
- Performs read-modify-write for sub-word stores, so the memory only ever sees aligned full-word accesses.

Parameters:
- ADDR_WIDTH, 32, width of request and memory addresses.
- DATA_WIDTH, 32, word width; fixed at 32, and other values are unsupported.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstN  input  1  asynchronous active-low reset.
- reqValid  input  1  request present.
- reqReady  output  1  unit idle, request will be accepted this edge.
- reqWrite  input  1  1 = store, 0 = load.
- reqSize  input  3  funct3-style code: 000 b, 001 h, 010 w, 100 bu, 101 hu; all others illegal.
- reqAddr  input  ADDR_WIDTH  byte address.
- reqWData  input  32  store data, right-aligned.
- respValid  output  1  one-cycle completion pulse.
- respData  output  32  extended load data, valid while respValid.
- respErr  output  1  request rejected, valid while respValid.
- memAdr  output  ADDR_WIDTH  word-aligned address to memory ([1:0] = 00).
- memWriteData  output  32  full word to memory.
- memWrite  output  1  memory write enable.
- memReadData  input  32  combinational read word from memory.

Behaviour:
- Reset (async, rstN = 0): state IDLE; reqReady = 1; respValid = 0; respData = 0; respErr = 0; memWrite = 0; memAdr = 0; memWriteData = 0.
- Reset mid-operation aborts the operation. memWrite is decoded from state, so it drops in the same instant reset asserts. No partial write completes after reset.
- FSM states: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - reqReady = 1.
  - On reqValid at an edge, register op, size, address and data, then go to ACCESS.
  - If the request is illegal (bad size, or misaligned when the check is enabled), register respErr = 1 and go directly to RESP with no memory access.
- ACCESS:
  - memAdr = {addr[31:2], 00}.
  - Load: at the edge, extract the lane and extend into respData, then go to RESP.
    - Byte lane = addr[1:0]; halfword lane = addr[1].
    - b/h sign-extend; bu/hu zero-extend; w passes through.
  - Store word: memWrite = 1 and memWriteData = wdata this cycle, then go to RESP.
  - Store byte/half: memWrite = 0. Register the merge of memReadData with wdata[7:0] / wdata[15:0] in the selected lane, then go to WRITE.
- WRITE: memWrite = 1, memWriteData = merged word, memAdr held; then go to RESP.
- RESP:
  - respValid = 1 for exactly one cycle, then go to IDLE.
  - respData = 0 for stores and errors.
  - respErr is cleared when the next request is accepted.
- Latency from accept edge to respValid:
  - Load and sw: 2 cycles.
  - sb/sh: 3 cycles.
  - Error: 1 cycle.
- reqReady = 0 in all states except IDLE. reqValid while busy is ignored, not queued.
- memWrite is never asserted in IDLE or RESP, and is asserted for at most one cycle per request.
- Inputs are sampled only at accept; later changes to reqAddr/reqWData have no effect.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined:
  - h/hu/sh with addr[0] = 1 → error.
  - w/sw with addr[1:0] != 00 → error.
  - An error performs no memory write and returns respData = 0.
- Undefined:
  - No alignment check.
  - addr[0] is ignored for halfwords; addr[1:0] are ignored for words.
  - respErr is asserted only for illegal reqSize.

Decomposition:
- Shared package holds:
  - size codes SIZE_B/H/W/BU/HU;
  - FSM state enum;
  - lane-select helper constants.
- One natural sub-module, lsu_lane_unit: combinational extract/extend and merge logic, parameter-free. Used by the FSM in both ACCESS paths.

Test Plan:
- Loads: word 0x100 = 0x8899AABB. lb 0x101 → 0xFFFFFFAA; lbu 0x103 → 0x00000088; lh 0x102 → 0xFFFF8899; lhu 0x100 → 0x0000AABB; lw 0x100 → 0x8899AABB. respValid appears exactly 2 cycles after each accept.
- Stores: sb 0x102 with data 0x12 → word becomes 0x8812AABB, memWrite high for exactly 1 cycle, respValid at cycle 3. Then sh 0x100 with data 0x3456 → 0x88123456. Then sw 0x104 with data 0xDEADBEEF → written in 2 cycles.
- Back-to-back: reqValid held high across a load and a store. The second request is accepted only in the IDLE cycle after RESP, and the busy cycles show reqReady = 0.
- Errors: reqSize 011 → respErr = 1 one cycle after accept, memWrite never high.
  - With LSU_MISALIGN_CHECK_EN defined: sw 0x102 → error, memory unchanged.
  - Without it: sw 0x102 writes the word at 0x100.
- Reset mid-operation: assert rstN = 0 during the ACCESS cycle of sh 0x100. memWrite drops immediately, memory stays unchanged, outputs take reset values, and reqReady = 1 after release.
